// File: rtl/bus_source_arbiter.sv
// One-hot bus source arbiter: round-robin with bounded hold and a lock override, grant registered one cycle after request.
// No backpressure: req is level-sensitive, and the owner keeps the bus until it releases, is preempted under contention, or clr is asserted.
module bus_source_arbiter #(
    parameter int NUM_SRC  = 24,
    parameter int IDX_W    = 5,
    parameter int MAX_HOLD = 4,
    parameter int HOLD_W   = 3
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [NUM_SRC-1:0] req,
    input  logic               lock,
    output logic [NUM_SRC-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;

    // Returns {found, index} of the first set bit scanning upward from start, wrapping at NUM_SRC-1.
    function automatic logic [IDX_W:0] pick_first(input logic [NUM_SRC-1:0] r,
                                                  input logic [IDX_W-1:0]   start);
        logic [IDX_W:0] res;
        int             pos;
        res = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            pos = int'(start) + k;
            if (pos >= NUM_SRC) begin
                pos = pos - NUM_SRC;
            end
            if (r[pos]) begin
                res = {1'b1, IDX_W'(pos)};
            end
        end
        return res;
    endfunction

    function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] nxt;
        if (idx == IDX_W'(NUM_SRC - 1)) begin
            nxt = '0;
        end else begin
            nxt = idx + 1'b1;
        end
        return nxt;
    endfunction

    logic [IDX_W-1:0]   owner;
    logic [NUM_SRC-1:0] owner_mask;
    logic [NUM_SRC-1:0] others_req;
    logic [IDX_W-1:0]   ptr_after_owner;
    logic [IDX_W:0]     idle_pick;
    logic [IDX_W:0]     rot_pick;
    logic               owner_req;
    logic               hold_expired;
    logic               preempt;

    always_comb begin
        owner           = grant_idx_q;
        owner_mask      = NUM_SRC'(1) << owner;
        others_req      = req & ~owner_mask;
        owner_req       = |(req & owner_mask);
        ptr_after_owner = inc_wrap(owner);
        idle_pick       = pick_first(req, ptr_q);
        rot_pick        = pick_first(others_req, ptr_after_owner);
        hold_expired    = (MAX_HOLD != 0) && ({1'b0, hold_cnt_q} >= (HOLD_W + 1)'(MAX_HOLD));
        preempt         = !lock && hold_expired && (|others_req);
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;

        case (state_q)
            IDLE: begin
                if (idle_pick[IDX_W]) begin
                    state_d     = OWN;
                    grant_d     = NUM_SRC'(1) << idle_pick[IDX_W-1:0];
                    grant_idx_d = idle_pick[IDX_W-1:0];
                    hold_cnt_d  = HOLD_W'(1);
                end else begin
                    grant_d     = '0;
                    grant_idx_d = '0;
                end
            end

            OWN: begin
                if (!owner_req) begin
                    ptr_d = ptr_after_owner;
                    if (rot_pick[IDX_W]) begin
                        // Hand over directly so the bus never sees an idle gap.
                        grant_d     = NUM_SRC'(1) << rot_pick[IDX_W-1:0];
                        grant_idx_d = rot_pick[IDX_W-1:0];
                        hold_cnt_d  = HOLD_W'(1);
                    end else begin
                        state_d     = IDLE;
                        grant_d     = '0;
                        grant_idx_d = '0;
                        hold_cnt_d  = '0;
                    end
                end else if (preempt) begin
                    ptr_d       = ptr_after_owner;
                    grant_d     = NUM_SRC'(1) << rot_pick[IDX_W-1:0];
                    grant_idx_d = rot_pick[IDX_W-1:0];
                    hold_cnt_d  = HOLD_W'(1);
                end else if (hold_cnt_q != '1) begin
                    // Counter keeps running under lock so preemption fires as soon as lock drops.
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d     = IDLE;
                grant_d     = '0;
                grant_idx_d = '0;
                hold_cnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            grant_q     <= '0;
            grant_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = |grant_q;

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Scoreboard bench for bus_source_arbiter: directed scenarios then randomized traffic vs. a queue-free reference model.
module tb_bus_source_arbiter;

    localparam int N        = 24;
    localparam int IW       = 5;
    localparam int MAXH     = 4;
    localparam int HW       = 3;
    localparam int HOLD_SAT = (1 << HW) - 1;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic [N-1:0]  req = '0;
    logic          lock = 1'b0;
    logic [N-1:0]  grant;
    logic [IW-1:0] grant_idx;
    logic          grant_valid;

    bus_source_arbiter #(
        .NUM_SRC (N),
        .IDX_W   (IW),
        .MAX_HOLD(MAXH),
        .HOLD_W  (HW)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .req        (req),
        .lock       (lock),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  g;
        logic [IW-1:0] idx;
        logic          vld;
        string         tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: owner is -1 when the bus is idle.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;

    function automatic int search(input logic [N-1:0] r, input int from, input int excl);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (from + k) % N;
            if (i != excl && r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input logic c, input logic [N-1:0] r, input logic l);
        int others;
        if (c) begin
            m_owner = -1;
            m_ptr   = 0;
            m_hold  = 0;
        end else if (m_owner < 0) begin
            m_owner = search(r, m_ptr, -1);
            if (m_owner >= 0) m_hold = 1;
        end else begin
            others = search(r, 0, m_owner);
            if (!r[m_owner]) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = search(r, m_ptr, m_owner);
                m_hold  = (m_owner >= 0) ? 1 : 0;
            end else if (!l && MAXH != 0 && m_hold >= MAXH && others >= 0) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = search(r, m_ptr, m_owner);
                m_hold  = 1;
            end else if (m_hold < HOLD_SAT) begin
                m_hold = m_hold + 1;
            end
        end
    endtask

    task automatic step(input logic c, input logic [N-1:0] r, input logic l, input string tag);
        exp_t e;
        @(negedge clk);
        clr  = c;
        req  = r;
        lock = l;
        @(posedge clk);
        model_step(c, r, l);
        e.g   = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        e.idx = (m_owner >= 0) ? IW'(m_owner) : '0;
        e.vld = (m_owner >= 0);
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Monitor: the DUT presents a grant every cycle, so one expectation is consumed per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (grant !== e.g) begin
                    n_fail++;
                    $display("FAIL %s grant: got %h want %h", e.tag, grant, e.g);
                end
                n_tests++;
                if (grant_idx !== e.idx) begin
                    n_fail++;
                    $display("FAIL %s grant_idx: got %0d want %0d", e.tag, grant_idx, e.idx);
                end
                n_tests++;
                if (grant_valid !== e.vld) begin
                    n_fail++;
                    $display("FAIL %s grant_valid: got %b want %b", e.tag, grant_valid, e.vld);
                end
            end
        end
    end

    initial begin
        logic [N-1:0] r;
        logic         l;
        logic         c;

        // Reset with every source requesting, then first grant goes to source 0.
        step(1'b1, '1, 1'b0, "reset");
        step(1'b1, '1, 1'b0, "reset");
        step(1'b0, '1, 1'b0, "post_reset");
        step(1'b1, '0, 1'b0, "reset");

        // Single requester keeps the bus regardless of MAX_HOLD.
        for (int i = 0; i < 10; i++) step(1'b0, N'(1) << 20, 1'b0, "no_contention");
        step(1'b0, '0, 1'b0, "release_idle");
        step(1'b0, '0, 1'b0, "idle");

        // Two requesters rotate every MAX_HOLD cycles without an idle gap.
        for (int i = 0; i < 20; i++) step(1'b0, (N'(1) << 3) | (N'(1) << 17), 1'b0, "round_robin");

        // Lock holds owner 21 under contention; dropping lock preempts at once.
        step(1'b1, '0, 1'b0, "reset");
        step(1'b0, N'(1) << 21, 1'b0, "lock_setup");
        for (int i = 0; i < 20; i++) step(1'b0, (N'(1) << 21) | (N'(1) << 5), 1'b1, "lock_hold");
        step(1'b0, (N'(1) << 21) | (N'(1) << 5), 1'b0, "lock_drop");
        step(1'b0, (N'(1) << 21) | (N'(1) << 5), 1'b0, "lock_after");

        // Owner 23 releases; pointer wraps to 0.
        step(1'b1, '0, 1'b0, "reset");
        step(1'b0, N'(1) << 23, 1'b0, "wrap_setup");
        step(1'b0, (N'(1) << 23) | (N'(1) << 22) | N'(1), 1'b1, "wrap_hold");
        step(1'b0, (N'(1) << 22) | N'(1), 1'b0, "wrap_release");

        // Reset in the middle of ownership restores ptr to 0.
        step(1'b1, '0, 1'b0, "reset");
        for (int i = 0; i < 3; i++) step(1'b0, N'(1) << 10, 1'b0, "midop_own");
        step(1'b1, N'(1) << 10, 1'b0, "midop_clr");
        step(1'b0, '0, 1'b0, "midop_idle");
        step(1'b0, (N'(1) << 10) | (N'(1) << 11), 1'b0, "midop_regrant");

        // Randomized traffic with persistent, sparse request patterns.
        r = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int b = 0; b < N; b++) r[b] = ($urandom_range(0, 7) == 0);
            end else if ($urandom_range(0, 2) == 0) begin
                r[$urandom_range(0, N - 1)] ^= 1'b1;
            end
            l = ($urandom_range(0, 3) == 0);
            c = ($urandom_range(0, 99) == 0);
            step(c, r, l, "random");
        end

        repeat (3) @(posedge clk);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
